ram_arbiter: RTL and testbench

- Sequences the single-port, 512x32, synchronous-read data RAM of the RV32I core.
- Shares the RAM between two requesters: the instruction-fetch port (read-only) and the load/store data port.
- The RAM has no byte enables, so byte and halfword stores run as an internal read-modify-write.
- Sits between the core's fetch/LSU and the RAM. It drives the RAM's addr/din/write_en and consumes its dout.

---
 rtl/ram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port 512x32 sync-read RAM between the fetch port
// (read-only) and the load/store port. Sub-word stores run as read-modify-write.
// Ports: clk/rst_n; fetch i_req/i_addr -> i_ack/i_err/i_rdata;
//        data d_req/d_we/d_size/d_addr/d_wdata -> d_ack/d_err/d_rdata;
//        RAM side ram_addr/ram_din/ram_we out, ram_dout in (valid one cycle after addr).
// Latency: misaligned 1 cycle, word store 2, load/fetch 3, byte/half store 4.
// Backpressure: a requester holds req high until its ack; the loser of a tie waits.
// Option: define ARB_FIXED_PRIO_EN for fixed data-over-fetch priority
//         (default build is round-robin on a last_grant bit).
module ram_arbiter #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic              i_ack,
   output logic              i_err,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic              d_err,
   output logic [31:0]       d_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   output logic              ram_we,
   input  logic [31:0]       ram_dout
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

   state_t              state_q, state_d;
   logic                owner_q;       // 1 = data port owns the access
   logic                we_q;
   logic [1:0]          size_q;
   logic [1:0]          lane_q;
   logic [ADDR_W-1:0]   waddr_q;
   logic [31:0]         wdata_q;       // store data; overwritten by the merged word for RMW
   logic                err_q;
   logic [31:0]         i_rdata_q, d_rdata_q;

   logic                any_req;
   logic                pick_data;
   logic [31:0]         sel_addr;
   logic                sel_we;
   logic [1:0]          sel_size;
   logic                sel_mis;
   logic                word_store;

   // High address bits are deliberately ignored: the RAM address wraps.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, i_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

   assign any_req = i_req | d_req;

`ifdef ARB_FIXED_PRIO_EN
   assign pick_data = d_req;
`else
   logic last_grant_q;                 // 1 = data was granted last

   // On a tie, the requester not granted last time wins.
   assign pick_data = d_req & (~i_req | ~last_grant_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant_q <= 1'b0;
      else if (state_q == IDLE && any_req)
         last_grant_q <= pick_data;
   end
`endif

   assign sel_addr = pick_data ? d_addr : i_addr;
   assign sel_we   = pick_data & d_we;
   assign sel_size = pick_data ? d_size : 2'b10;  // fetch is always a word access

   // size[1] set covers both word encodings (10 and 11).
   always_comb begin
      sel_mis = 1'b0;
      if (sel_size[1])
         sel_mis = (sel_addr[1:0] != 2'b00);
      else if (sel_size[0])
         sel_mis = sel_addr[0];
   end

   assign word_store = we_q & size_q[1];

   function automatic logic [31:0] merge(input logic [31:0] old_w,
                                         input logic [31:0] new_w,
                                         input logic [1:0]  size,
                                         input logic [1:0]  lane);
      logic [31:0] m;
      m = old_w;
      if (size[0])
         m[{lane[1], 4'b0000} +: 16] = new_w[15:0];
      else
         m[{lane, 3'b000} +: 8] = new_w[7:0];
      return m;
   endfunction

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = sel_mis ? DONE : ISSUE;
         ISSUE:   state_d = word_store ? DONE : WAIT;
         WAIT:    state_d = we_q ? WRITE : DONE;
         WRITE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         size_q    <= 2'b00;
         lane_q    <= 2'b00;
         waddr_q   <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && any_req) begin
            owner_q <= pick_data;
            we_q    <= sel_we;
            size_q  <= sel_size;
            lane_q  <= sel_addr[1:0];
            waddr_q <= sel_addr[ADDR_W+1:2];
            wdata_q <= pick_data ? d_wdata : '0;
            err_q   <= sel_mis;
         end
         if (state_q == WAIT) begin
            if (we_q)
               wdata_q <= merge(ram_dout, wdata_q, size_q, lane_q);
            else if (owner_q)
               d_rdata_q <= ram_dout;
            else
               i_rdata_q <= ram_dout;
         end
      end
   end

   // RAM strobes decode straight from state so a reset kills a pending write at once.
   always_comb begin
      ram_we  = 1'b0;
      ram_din = '0;
      if ((state_q == ISSUE && word_store) || state_q == WRITE) begin
         ram_we  = 1'b1;
         ram_din = wdata_q;
      end
   end

   assign ram_addr = waddr_q;
   assign i_ack    = (state_q == DONE) & ~owner_q;
   assign d_ack    = (state_q == DONE) &  owner_q;
   assign i_err    = i_ack & err_q;
   assign d_err    = d_ack & err_q;
   assign i_rdata  = i_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ack, i_err;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [1:0]  d_size = 2'b10;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic        d_ack, d_err;
   logic [31:0] d_rdata;
   logic [8:0]  ram_addr;
   logic [31:0] ram_din;
   logic        ram_we;
   logic [31:0] ram_dout;

   ram_arbiter #(.ADDR_W(9)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Bench-side RAM: 512x32, synchronous read (read-before-write).
   logic [31:0] mem [512];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Transaction-level reference: memory image plus last loaded word per port.
   logic [31:0] m_mem [512];
   logic [31:0] m_ird, m_drd;

   task automatic model_txn(input bit pd, input bit we, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output bit err, output logic [31:0] rd,
                            output logic [31:0] din, output int wecnt);
      int idx, lane;
      logic [1:0] esz;
      logic [31:0] mask, newv;
      idx   = int'((addr / 4) % 512);
      esz   = pd ? sz : 2'b10;
      din   = '0;
      wecnt = 0;
      if (esz >= 2)      err = (addr % 4) != 0;
      else if (esz == 1) err = (addr % 2) != 0;
      else               err = 1'b0;
      if (err) begin
         lat = 1;
         rd  = pd ? m_drd : m_ird;
      end else if (!(pd && we)) begin
         lat = 3;
         rd  = m_mem[idx];
         if (pd) m_drd = rd; else m_ird = rd;
      end else begin
         if (esz >= 2) begin
            lat = 2;
            newv = wdata;
         end else begin
            lat = 4;
            if (esz == 0) begin
               lane = int'(addr % 4);
               mask = 32'hFF << (8 * lane);
               newv = (m_mem[idx] & ~mask) | ((wdata & 32'hFF) << (8 * lane));
            end else begin
               lane = int'((addr / 2) % 2);
               mask = 32'hFFFF << (16 * lane);
               newv = (m_mem[idx] & ~mask) | ((wdata & 32'hFFFF) << (16 * lane));
            end
         end
         m_mem[idx] = newv;
         din   = newv;
         wecnt = 1;
         rd    = m_drd;
      end
   endtask

   // Observations from the last run_txn.
   int          r_lat, r_wecnt, r_we_cyc, r_other;
   bit          r_err;
   logic [31:0] r_rdata, r_we_din;
   logic [8:0]  r_addr1;

   task automatic run_txn(input bit pd, input bit we, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wdata);
      int cyc;
      bit done;
      @(negedge clk);
      if (pd) begin
         d_req = 1'b1; d_we = we; d_size = sz; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      cyc = 0; done = 1'b0;
      r_lat = -1; r_wecnt = 0; r_we_cyc = -1; r_other = 0;
      r_err = 1'b0; r_rdata = '0; r_we_din = '0; r_addr1 = '0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) r_addr1 = ram_addr;
         if (ram_we) begin
            r_wecnt++; r_we_cyc = cyc; r_we_din = ram_din;
         end
         if (pd ? i_ack : d_ack) r_other++;
         if (pd ? d_ack : i_ack) begin
            done = 1'b1; r_lat = cyc;
            r_err   = pd ? d_err : i_err;
            r_rdata = pd ? d_rdata : i_rdata;
         end
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL txn_timeout actual=no_ack required=ack_within_20");
      end
      i_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic check_txn(input string tag, input logic [31:0] addr, input int elat,
                            input bit eerr, input logic [31:0] erd, input logic [31:0] edin,
                            input int ewecnt);
      check({tag, "_lat"}, r_lat, elat);
      check({tag, "_err"}, {31'd0, r_err}, {31'd0, eerr});
      check({tag, "_rdata"}, r_rdata, erd);
      check({tag, "_wecnt"}, r_wecnt, ewecnt);
      check({tag, "_other_ack"}, r_other, 0);
      if (ewecnt == 1) begin
         check({tag, "_we_cycle"}, r_we_cyc, elat - 1);
         check({tag, "_din"}, r_we_din, edin);
      end
      if (!eerr) check({tag, "_addr1"}, {23'd0, r_addr1}, (addr / 4) % 512);
   endtask

   task automatic pulse_reset;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_ird = '0; m_drd = '0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ctrl"}, {27'd0, i_ack, d_ack, i_err, d_err, ram_we}, 32'd0);
      check({tag, "_i_rdata"}, i_rdata, 32'd0);
      check({tag, "_d_rdata"}, d_rdata, 32'd0);
      check({tag, "_ram_addr"}, {23'd0, ram_addr}, 32'd0);
      check({tag, "_ram_din"}, ram_din, 32'd0);
   endtask

   typedef struct {
      bit          pd;
      bit          we;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      bit          err;
      logic [31:0] rdata;
      logic [31:0] din;
   } vec_t;

   initial begin
      vec_t vt [16];
      int   lat, wecnt, nmis, n, cyc, both;
      bit   err, exp_d, last_d, got;
      logic [31:0] rd, din, addr, wdata;
      bit   pd, we;
      logic [1:0] sz;

      for (int i = 0; i < 512; i++) begin
         mem[i]   = (i * 32'h01010101) ^ 32'h5A5A0000;
         m_mem[i] = (i * 32'h01010101) ^ 32'h5A5A0000;
      end
      mem[4] = 32'h12345678; m_mem[4] = 32'h12345678;
      m_ird = '0; m_drd = '0;

      //          pd we  sz     addr          wdata         lat err rdata         din
      vt[0]  = '{0, 0, 2'b10, 32'h10,       32'h0,        3, 0, 32'h12345678, 32'h0};
      vt[1]  = '{1, 1, 2'b10, 32'h20,       32'hDEADBEEF, 2, 0, 32'h00000000, 32'hDEADBEEF};
      vt[2]  = '{1, 0, 2'b10, 32'h20,       32'h0,        3, 0, 32'hDEADBEEF, 32'h0};
      vt[3]  = '{1, 1, 2'b00, 32'h22,       32'h000000A5, 4, 0, 32'hDEADBEEF, 32'hDEA5BEEF};
      vt[4]  = '{1, 0, 2'b10, 32'h20,       32'h0,        3, 0, 32'hDEA5BEEF, 32'h0};
      vt[5]  = '{1, 1, 2'b01, 32'h22,       32'hFFFF1234, 4, 0, 32'hDEA5BEEF, 32'h1234BEEF};
      vt[6]  = '{1, 0, 2'b10, 32'h20,       32'h0,        3, 0, 32'h1234BEEF, 32'h0};
      vt[7]  = '{1, 0, 2'b10, 32'h21,       32'h0,        1, 1, 32'h1234BEEF, 32'h0};
      vt[8]  = '{0, 0, 2'b10, 32'h02,       32'h0,        1, 1, 32'h12345678, 32'h0};
      vt[9]  = '{1, 1, 2'b01, 32'h23,       32'h0000FFFF, 1, 1, 32'h1234BEEF, 32'h0};
      vt[10] = '{1, 1, 2'b11, 32'h24,       32'hCAFEF00D, 2, 0, 32'h1234BEEF, 32'hCAFEF00D};
      vt[11] = '{1, 0, 2'b11, 32'h24,       32'h0,        3, 0, 32'hCAFEF00D, 32'h0};
      vt[12] = '{1, 1, 2'b00, 32'h27,       32'h12345699, 4, 0, 32'hCAFEF00D, 32'h99FEF00D};
      vt[13] = '{1, 0, 2'b00, 32'h25,       32'h0,        3, 0, 32'h99FEF00D, 32'h0};
      vt[14] = '{1, 0, 2'b10, 32'h820,      32'h0,        3, 0, 32'h1234BEEF, 32'h0};
      vt[15] = '{0, 0, 2'b10, 32'h24,       32'h0,        3, 0, 32'h99FEF00D, 32'h0};

      // Reset state.
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;

      // Directed vectors.
      for (int k = 0; k < 16; k++) begin
         run_txn(vt[k].pd, vt[k].we, vt[k].sz, vt[k].addr, vt[k].wdata);
         model_txn(vt[k].pd, vt[k].we, vt[k].sz, vt[k].addr, vt[k].wdata, lat, err, rd, din, wecnt);
         check_txn($sformatf("vec%0d", k), vt[k].addr, vt[k].lat, vt[k].err, vt[k].rdata,
                   vt[k].din, (vt[k].pd && vt[k].we && !vt[k].err) ? 1 : 0);
      end

      // Both ports requesting continuously after reset.
      pulse_reset();
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h20;
      last_d = 1'b0; n = 0; cyc = 0; both = 0;
      while (n < 6 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (i_ack && d_ack) both++;
         if (i_ack || d_ack) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_d = 1'b1;
`else
            exp_d = ~last_d;
`endif
            last_d = exp_d;
            check($sformatf("tie_grant%0d", n), {31'd0, d_ack}, {31'd0, exp_d});
            n++;
         end
      end
      if (n < 6) begin
         checks++; failures++;
         $display("FAIL tie_timeout actual=%0d_acks required=6", n);
      end
      check("tie_both_ack", both, 0);
      d_req = 1'b0;
      got = 1'b0; cyc = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (i_ack || d_ack) begin
            got = 1'b1;
            check("tie_after_drop", {30'd0, i_ack, d_ack}, 32'd2);
         end
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL tie_after_drop_timeout actual=no_ack required=i_ack");
      end
      i_req = 1'b0;

      // Reset pulsed during the WAIT cycle of a byte store.
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 32'h22; d_wdata = 32'h5A;
      @(negedge clk);
      check("rmw_rst_we_c1", {31'd0, ram_we}, 32'd0);
      @(negedge clk);
      check("rmw_rst_we_c2", {31'd0, ram_we}, 32'd0);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("rmw_rst");
      d_req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rmw_rst_we_hold", {31'd0, ram_we}, 32'd0);
      end
      rst_n = 1'b1;
      m_ird = '0; m_drd = '0;
      check("rmw_rst_mem8", mem[8], m_mem[8]);
      run_txn(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
      model_txn(1'b1, 1'b0, 2'b10, 32'h20, 32'h0, lat, err, rd, din, wecnt);
      check_txn("post_rst_load", 32'h20, lat, err, rd, din, wecnt);

      // Randomized traffic against the reference model.
      for (int k = 0; k < 150; k++) begin
         pd = $urandom_range(0, 1) == 1;
         we = pd && ($urandom_range(0, 1) == 1);
         sz = pd ? 2'($urandom_range(0, 3)) : 2'b10;
         if ($urandom_range(0, 3) == 0) addr = $urandom;
         else addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
         wdata = $urandom;
         run_txn(pd, we, sz, addr, wdata);
         model_txn(pd, we, sz, addr, wdata, lat, err, rd, din, wecnt);
         check_txn($sformatf("rnd%0d", k), addr, lat, err, rd, din, wecnt);
      end

      nmis = 0;
      for (int i = 0; i < 512; i++)
         if (mem[i] !== m_mem[i]) nmis++;
      check("mem_sweep", nmis, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
